// File: rtl/hotspot_pos_ctrl.sv
`timescale 1ns/1ps
// hotspot_pos_ctrl
// Takes sound-source coordinates over a valid/ready handshake and limits them
// so the 49x49 hotspot stays on the 480x272 panel. The clamped value is
// smoothed with a shift-based IIR filter. The overlay position is updated only
// on a frame start, so the hotspot never tears mid-frame. The hotspot is
// blanked after TIMEOUT_FRAMES frame starts pass without an update.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no sample in flight, ready for a new one
// CLAMP  | limit the latched raw sample to the on-screen window
// FILTER | load the filter directly (first sample) or apply the IIR step
// HOLD   | filtered value waits for the next frame start to be committed
module hotspot_pos_ctrl #(
    parameter int H_RES          = 480,
    parameter int V_RES          = 272,
    parameter int HALF           = 24,
    parameter int ALPHA_SHIFT    = 2,
    parameter int TIMEOUT_FRAMES = 30,
    parameter bit VS_POL         = 1'b1
) (
    input  logic        clk_pix,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_x,
    input  logic [15:0] in_y,
    input  logic        vs,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y,
    output logic        hotspot_en,
    output logic        frame_commit
);

    localparam int MISS_W = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [MISS_W-1:0] MISS_MAX  = MISS_W'(TIMEOUT_FRAMES);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(TIMEOUT_FRAMES - 1);
    localparam logic [MISS_W-1:0] MISS_ONE  = MISS_W'(1);

    localparam logic [15:0] X_MIN  = 16'(HALF);
    localparam logic [15:0] X_MAX  = 16'(H_RES - 1 - HALF);
    localparam logic [15:0] Y_MIN  = 16'(HALF);
    localparam logic [15:0] Y_MAX  = 16'(V_RES - 1 - HALF);
    localparam logic [15:0] X_HOME = 16'(H_RES / 2);
    localparam logic [15:0] Y_HOME = 16'(V_RES / 2);

    typedef enum logic [1:0] {
        IDLE,
        CLAMP,
        FILTER,
        HOLD
    } state_t;

    state_t              state;
    logic                vs_d;
    logic                first_flag;
    logic [MISS_W-1:0]   miss_cnt;
    logic [15:0]         raw_x, raw_y;
    logic [15:0]         clp_x, clp_y;
    logic [15:0]         acc_x, acc_y;
    logic signed [16:0]  diff_x, diff_y;
    logic                frame_tick;
    logic                accept;

    // A frame starts on the cycle vs enters its active level.
    assign frame_tick = (vs == VS_POL) && (vs_d != VS_POL);
    assign in_ready   = !rst && ((state == IDLE) || (state == HOLD));
    assign accept     = in_valid && in_ready;

    function automatic logic [15:0] clamp16(input logic [15:0] v,
                                            input logic [15:0] lo,
                                            input logic [15:0] hi);
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

    // Signed distance from the accumulator to the new clamped target.
    always_comb begin
        diff_x = $signed({1'b0, clp_x}) - $signed({1'b0, acc_x});
        diff_y = $signed({1'b0, clp_y}) - $signed({1'b0, acc_y});
    end

    // Sample pipeline, frame-synchronous commit and no-update timeout.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            state        <= IDLE;
            vs_d         <= VS_POL;
            first_flag   <= 1'b1;
            miss_cnt     <= '0;
            raw_x        <= '0;
            raw_y        <= '0;
            clp_x        <= X_HOME;
            clp_y        <= Y_HOME;
            acc_x        <= X_HOME;
            acc_y        <= Y_HOME;
            pix_x        <= X_HOME;
            pix_y        <= Y_HOME;
            hotspot_en   <= 1'b0;
            frame_commit <= 1'b0;
        end else begin
            vs_d         <= vs;
            frame_commit <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        raw_x <= in_x;
                        raw_y <= in_y;
                        state <= CLAMP;
                    end
                end
                CLAMP: begin
                    clp_x <= clamp16(raw_x, X_MIN, X_MAX);
                    clp_y <= clamp16(raw_y, Y_MIN, Y_MAX);
                    state <= FILTER;
                end
                FILTER: begin
                    if (first_flag) begin
                        acc_x      <= clp_x;
                        acc_y      <= clp_y;
                        first_flag <= 1'b0;
                    end else begin
                        // Floor-rounded step keeps the result between acc and target.
                        acc_x <= acc_x + 16'(diff_x >>> ALPHA_SHIFT);
                        acc_y <= acc_y + 16'(diff_y >>> ALPHA_SHIFT);
                    end
                    state <= HOLD;
                end
                HOLD: begin
                    if (frame_tick) begin
                        pix_x        <= acc_x;
                        pix_y        <= acc_y;
                        hotspot_en   <= 1'b1;
                        frame_commit <= 1'b1;
                        miss_cnt     <= '0;
                    end
                    // A new sample supersedes the pending one; the filter sees both.
                    if (accept) begin
                        raw_x <= in_x;
                        raw_y <= in_y;
                        state <= CLAMP;
                    end else if (frame_tick) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Frame starts outside HOLD have nothing to commit and count as misses.
            // Placed last so a timeout re-arms the direct load even mid-filter.
            if (frame_tick && (state != HOLD) && (miss_cnt != MISS_MAX)) begin
                miss_cnt <= miss_cnt + MISS_ONE;
                if (miss_cnt == MISS_LAST) begin
                    hotspot_en <= 1'b0;
                    first_flag <= 1'b1;
                end
            end
        end
    end

endmodule
